// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction-fetch front end.
package fetch_pkg;

  localparam int InstrW = 32;
  localparam int PcW    = 32;

  typedef struct packed {
    logic [PcW-1:0]    pc;
    logic [InstrW-1:0] instr;
  } fetch_entry_t;

  localparam logic [PcW-1:0] PC_INC = 32'd4;

endpackage

// File: rtl/fetch_fifo.sv
// Show-ahead FIFO of fetched {pc, instr} entries. The head entry is always
// visible on 'head'. A flush empties the queue in one cycle.
module fetch_fifo
  import fetch_pkg::*;
#(
  parameter int Depth = 4
) (
  input  logic                             clk,
  input  logic                             rst,
  input  logic                             push,
  input  fetch_entry_t                     entry_in,
  input  logic                             pop,
  input  logic                             flush,
  output fetch_entry_t                     head,
  output logic [$clog2(Depth+1)-1:0]       count,
  output logic                             full,
  output logic                             empty
);

  localparam int AW = $clog2(Depth);
  localparam int CW = $clog2(Depth+1);
  localparam logic [CW-1:0] DEPTH_C = Depth[CW-1:0];

  fetch_entry_t   mem [Depth];
  logic [AW-1:0]  rd_ptr;
  logic [AW-1:0]  wr_ptr;
  logic           do_push;
  logic           do_pop;

  // A push into a full queue is only honoured if the head leaves in the same cycle.
  always_comb begin
    do_push = push && (!full || pop);
    do_pop  = pop && !empty;
  end

  assign head  = mem[rd_ptr];
  assign full  = (count == DEPTH_C);
  assign empty = (count == '0);

  // Storage, pointers and occupancy; pointers wrap naturally since Depth is a power of 2.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
      for (int i = 0; i < Depth; i++) begin
        mem[i] <= '0;
      end
    end else if (flush) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) begin
        mem[wr_ptr] <= entry_in;
        wr_ptr      <= wr_ptr + AW'(1);
      end
      if (do_pop) begin
        rd_ptr <= rd_ptr + AW'(1);
      end
      count <= count + CW'(do_push) - CW'(do_pop);
    end
  end

endmodule

// File: rtl/instr_fetch_queue.sv
// Instruction-fetch front end: sequential PC generation, in-order requests to a
// variable-latency memory, response buffering and branch flush/redirect.
module instr_fetch_queue
  import fetch_pkg::*;
#(
  parameter int             Depth   = 4,
  parameter logic [PcW-1:0] ResetPC = 32'h0000_0000
) (
  input  logic              clk,
  input  logic              rst,
  output logic              imem_req,
  output logic [PcW-1:0]    imem_addr,
  input  logic              imem_gnt,
  input  logic              imem_rvalid,
  input  logic [InstrW-1:0] imem_rdata,
  input  logic              redirect,
  input  logic [PcW-1:0]    redirect_pc,
  input  logic              deq_ready,
  output logic              out_valid,
  output logic [PcW-1:0]    out_pc,
  output logic [InstrW-1:0] out_instr
);

  localparam int CW = $clog2(Depth+1);
  localparam logic [CW:0] DEPTH_OCC = Depth[CW:0];

  logic [PcW-1:0] fetch_pc;
  logic [PcW-1:0] rsp_pc;
  logic [CW-1:0]  outstanding;
  logic [CW-1:0]  discard;
  logic [CW-1:0]  fifo_count;
  logic [CW:0]    occupancy;
  logic           fifo_full;
  logic           fifo_empty;
  logic           accept;
  logic           push;
  logic           pop;
  fetch_entry_t   head;
  fetch_entry_t   rsp_entry;

  // Issue only while buffered plus in-flight words fit in the queue; a redirect
  // suppresses issue, enqueue and dequeue for its cycle.
  always_comb begin
    occupancy = {1'b0, fifo_count} + {1'b0, outstanding};
    imem_req  = rst && !redirect && !fifo_full && (occupancy < DEPTH_OCC);
    accept    = imem_req && imem_gnt;
    push      = imem_rvalid && !redirect && (discard == '0);
    out_valid = !fifo_empty && !redirect;
    pop       = out_valid && deq_ready;
  end

  assign rsp_entry = '{pc: rsp_pc, instr: imem_rdata};
  assign imem_addr = fetch_pc;
  assign out_pc    = head.pc;
  assign out_instr = head.instr;

  // Request and response PCs advance independently and both restart on redirect.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      fetch_pc <= ResetPC;
      rsp_pc   <= ResetPC;
    end else if (redirect) begin
      fetch_pc <= redirect_pc;
      rsp_pc   <= redirect_pc;
    end else begin
      if (accept) begin
        fetch_pc <= fetch_pc + PC_INC;
      end
      if (push) begin
        rsp_pc <= rsp_pc + PC_INC;
      end
    end
  end

  // Every in-flight word at redirect time is stale; those still to arrive are discarded.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      outstanding <= '0;
      discard     <= '0;
    end else if (redirect) begin
      outstanding <= outstanding - CW'(imem_rvalid);
      discard     <= outstanding - CW'(imem_rvalid);
    end else begin
      outstanding <= outstanding + CW'(accept) - CW'(imem_rvalid);
      if (imem_rvalid && (discard != '0)) begin
        discard <= discard - CW'(1);
      end
    end
  end

  fetch_fifo #(.Depth(Depth)) u_fifo (
    .clk      (clk),
    .rst      (rst),
    .push     (push),
    .entry_in (rsp_entry),
    .pop      (pop),
    .flush    (redirect),
    .head     (head),
    .count    (fifo_count),
    .full     (fifo_full),
    .empty    (fifo_empty)
  );

  // A response with nothing in flight means the memory broke the protocol.
  assert property (@(posedge clk) disable iff (!rst) imem_rvalid |-> (outstanding != '0));

  // Buffered plus in-flight words never exceed the queue capacity.
  assert property (@(posedge clk) disable iff (!rst) occupancy <= DEPTH_OCC);

endmodule

// File: doc/instr_fetch_queue.md
Name: instr_fetch_queue

Overview:
Instruction-fetch front end that sits directly upstream of the IF/ID pipe register of the 5-stage datapath. It generates sequential PCs, issues in-order requests to a variable-latency instruction memory, and buffers returned instructions with their PCs in a small queue. It presents one instruction per cycle to IF/ID, holds on hazard stalls, and flushes and redirects on a taken branch.

Parameters:
Depth, 4, queue entries and maximum in-flight requests; power of 2, at least 2.
ResetPC, 32'h0000_0000, first fetch address after reset.

Ports:
clk  in  1  clock; all state updates on the rising edge.
rst  in  1  asynchronous, active-low reset.
imem_req  out  1  request valid.
imem_addr  out  32  request address; equals the current fetch PC.
imem_gnt  in  1  memory accepts the request this cycle; the request is accepted when imem_req and imem_gnt are both high.
imem_rvalid  in  1  response valid; responses return in order, at least 1 cycle after acceptance.
imem_rdata  in  32  instruction word.
redirect  in  1  taken branch; flush and restart at redirect_pc (datapath PCSrc).
redirect_pc  in  32  branch target (datapath PC_beq).
deq_ready  in  1  consumer takes the head entry (datapath IF_ID_Write).
out_valid  out  1  head entry is valid.
out_pc  out  32  PC of the head instruction.
out_instr  out  32  head instruction word.

Behaviour:
- Reset (rst low, asynchronous):
  - fetch_pc = rsp_pc = ResetPC.
  - Queue count, outstanding and discard all = 0.
  - Outputs: out_valid = 0, imem_req = 0, out_pc = 0, out_instr = 0.
  - Fetching starts on the first rising edge after rst deasserts.
- Issue rule:
  - imem_req = !redirect && (count + outstanding < Depth).
  - On acceptance: fetch_pc += 4 (wraps modulo 2^32) and outstanding += 1.
- Response rule:
  - When imem_rvalid is high and discard == 0: enqueue {rsp_pc, imem_rdata}, then rsp_pc += 4 and outstanding -= 1.
  - When imem_rvalid is high and discard > 0: drop the word, discard -= 1, outstanding -= 1.
- Dequeue:
  - Show-ahead queue; out_valid/out_pc/out_instr are driven combinationally from the head entry.
  - When out_valid && deq_ready: pop the head. The next entry is visible in the following cycle.
  - When deq_ready is low: the head is held stable.
- Redirect, with priority over everything else in the same cycle:
  - out_valid is forced 0 in that cycle and no pop occurs.
  - Next cycle: count = 0 and fetch_pc = rsp_pc = redirect_pc.
  - discard = outstanding minus 1 if imem_rvalid was high that cycle, otherwise outstanding. A response arriving in the redirect cycle is dropped.
  - Issue resumes in the next cycle. The first post-redirect instruction reaches out_valid no earlier than 2 cycles after redirect, given 1-cycle memory latency.
- Counters:
  - count and outstanding are $clog2(Depth+1) bits wide; count + outstanding <= Depth always holds.
  - The queue never overflows by construction. A response arriving with outstanding == 0 is a protocol violation, checked only by assertion.
- Boundary conditions:
  - Full queue (count == Depth): imem_req = 0.
  - Empty queue: out_valid = 0.
  - Simultaneous enqueue and pop with count == Depth-1 or count == 1: both take effect and count is unchanged.
  - Back-to-back redirects: the second overrides the first. discard is recomputed from the current outstanding.
  - Reset asserted mid-transfer: all state clears immediately. The memory side is reset by the same rst, so no stale responses are expected.
- Throughput: with 1-cycle memory latency, always-asserted imem_gnt and deq_ready high, the block sustains one instruction per cycle after a 2-cycle fill.

Decomposition:
- Package fetch_pkg holds:
  - InstrW = 32 and PcW = 32.
  - typedef struct packed { logic [PcW-1:0] pc; logic [InstrW-1:0] instr; } fetch_entry_t.
  - PC_INC = 32'd4.
- Sub-module fetch_fifo: a synchronous show-ahead FIFO of fetch_entry_t with push, pop, flush, count, full and empty. It uses the same clk and active-low asynchronous rst.
- The top level holds the PC, outstanding and discard counters and the issue logic.

Test Plan:
- Reset then stream: after rst rises, with gnt=1, 1-cycle latency and deq_ready=1 → out_pc sequence 0x0, 0x4, 0x8, … with out_valid continuous from cycle 2.
- Stall: hold deq_ready=0 for 10 cycles → count saturates at 4, imem_req drops, out_pc stays 0x0; release → 0x4, 0x8, 0xC, 0x10 follow on consecutive cycles.
- Redirect with 3 in flight (4-cycle latency) to 0x100 → the 3 late responses are dropped, next out_pc = 0x100, then 0x104.
- Redirect in the same cycle as imem_rvalid → that word never appears; out_valid is 0 in the redirect cycle.
- Grant backpressure: imem_gnt toggles 1,0,0,1 → imem_addr holds while gnt=0; PCs emerge gap-free 0x0, 0x4, 0x8 with no duplicates.
- Wrap and reset: ResetPC = 0xFFFF_FFF8 → PCs 0xFFFF_FFF8, 0xFFFF_FFFC, 0x0. Assert rst mid-stream → out_valid = 0 and imem_req = 0 immediately.
